// File: rtl/flag_update_sequencer_if.sv
// Request/strobe bundle between the microcode sequencer and the F-register
// write sequencer.
interface flag_update_sequencer_if #(
  parameter int SEL_W   = 6,
  parameter int CLASS_W = 4
);
  logic               upd_valid;
  logic [CLASS_W-1:0] upd_class;
  logic               upd_repeat;
  logic               popf_valid;
  logic               ex_valid;
  logic [7:0]         F;
  logic               ready;
  logic               PF_Write_S;
  logic               PF_Write_Z;
  logic               PF_Write_H;
  logic               PF_Write_PV;
  logic               PF_Write_N;
  logic               PF_Write_C;
  logic [SEL_W-1:0]   PF_Select;
  logic               PR_Write_F;
  logic               PR_Ex;
  logic               rpt_valid;
  logic               rpt_taken;

  modport master (
    output upd_valid, upd_class, upd_repeat, popf_valid, ex_valid, F,
    input  ready, PF_Write_S, PF_Write_Z, PF_Write_H, PF_Write_PV,
           PF_Write_N, PF_Write_C, PF_Select, PR_Write_F, PR_Ex,
           rpt_valid, rpt_taken
  );

  modport slave (
    input  upd_valid, upd_class, upd_repeat, popf_valid, ex_valid, F,
    output ready, PF_Write_S, PF_Write_Z, PF_Write_H, PF_Write_PV,
           PF_Write_N, PF_Write_C, PF_Select, PR_Write_F, PR_Ex,
           rpt_valid, rpt_taken
  );
endinterface

// File: rtl/flag_update_sequencer.sv
// Sequences every write to F: arbitrates POP AF, ALU flag updates and EX AF,AF',
// and produces the repeat decision for LDI/LDD/CPI/CPD block forms.
module flag_update_sequencer #(
  parameter int SEL_W   = 6,
  parameter int CLASS_W = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  flag_update_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, DECIDE} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_POPF, SRC_UPD, SRC_EX} src_t;

  localparam logic [CLASS_W-1:0] CLS_BLOCK_LD = CLASS_W'(8);
  localparam logic [CLASS_W-1:0] CLS_BLOCK_CP = CLASS_W'(9);

  state_t             state;
  logic               ready_q;
  logic [5:0]         strobe_q;
  logic [SEL_W-1:0]   select_q;
  logic               write_f_q;
  logic               ex_q;
  logic               rpt_valid_q;
  logic               rpt_taken_q;

  logic               pend_upd;
  logic [CLASS_W-1:0] pend_upd_class;
  logic               pend_upd_repeat;
  logic               pend_ex;
  logic [CLASS_W-1:0] cur_class;
  logic               cur_repeat;

  src_t               pick;
  logic [CLASS_W-1:0] pick_class;
  logic               pick_repeat;
  logic [5:0]         pick_mask;
  logic [SEL_W-1:0]   pick_sel;
  logic               pick_reserved;
  logic               nxt_pend_upd;
  logic [CLASS_W-1:0] nxt_pend_upd_class;
  logic               nxt_pend_upd_repeat;
  logic               nxt_pend_ex;

  // Mask bit order is {S, Z, H, PV, N, C}.
  always_comb begin
    pick_mask     = 6'b000000;
    pick_sel      = '0;
    pick_reserved = 1'b0;
    case (int'(pick_class))
      0:       begin pick_mask = 6'b111111; pick_sel = SEL_W'(7);  end
      1:       begin pick_mask = 6'b111111; pick_sel = SEL_W'(15); end
      2:       begin pick_mask = 6'b111111; pick_sel = SEL_W'(19); end
      3:       begin pick_mask = 6'b111111; pick_sel = SEL_W'(21); end
      4:       begin pick_mask = 6'b111110; pick_sel = SEL_W'(23); end
      5:       begin pick_mask = 6'b001011; pick_sel = SEL_W'(26); end
      6:       begin pick_mask = 6'b001011; pick_sel = SEL_W'(28); end
      7:       begin pick_mask = 6'b111111; pick_sel = SEL_W'(24); end
      8:       begin pick_mask = 6'b001110; pick_sel = SEL_W'(17); end
      9:       begin pick_mask = 6'b111110; pick_sel = SEL_W'(34); end
      10:      begin pick_mask = 6'b001011; pick_sel = SEL_W'(29); end
      11:      begin pick_mask = 6'b111101; pick_sel = SEL_W'(22); end
      default: pick_reserved = 1'b1;
    endcase
  end

  // Fresh requests are taken only in IDLE; parked losers drain once any repeat decision is out.
  always_comb begin
    pick                = SRC_NONE;
    pick_class          = pend_upd_class;
    pick_repeat         = pend_upd_repeat;
    nxt_pend_upd        = pend_upd;
    nxt_pend_upd_class  = pend_upd_class;
    nxt_pend_upd_repeat = pend_upd_repeat;
    nxt_pend_ex         = pend_ex;
    if (state == IDLE && ready_q) begin
      if (bus.popf_valid) begin
        pick                = SRC_POPF;
        nxt_pend_upd        = bus.upd_valid;
        nxt_pend_upd_class  = bus.upd_class;
        nxt_pend_upd_repeat = bus.upd_repeat;
        nxt_pend_ex         = bus.ex_valid;
      end else if (bus.upd_valid) begin
        pick        = SRC_UPD;
        pick_class  = bus.upd_class;
        pick_repeat = bus.upd_repeat;
        nxt_pend_ex = bus.ex_valid;
      end else if (bus.ex_valid) begin
        pick = SRC_EX;
      end
    end else if ((state == ISSUE && !cur_repeat) || state == DECIDE) begin
      if (pend_upd) begin
        pick         = SRC_UPD;
        nxt_pend_upd = 1'b0;
      end else if (pend_ex) begin
        pick        = SRC_EX;
        nxt_pend_ex = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      ready_q         <= 1'b1;
      strobe_q        <= '0;
      select_q        <= '0;
      write_f_q       <= 1'b0;
      ex_q            <= 1'b0;
      rpt_valid_q     <= 1'b0;
      rpt_taken_q     <= 1'b0;
      pend_upd        <= 1'b0;
      pend_upd_class  <= '0;
      pend_upd_repeat <= 1'b0;
      pend_ex         <= 1'b0;
      cur_class       <= '0;
      cur_repeat      <= 1'b0;
    end else begin
      strobe_q        <= '0;
      select_q        <= '0;
      write_f_q       <= 1'b0;
      ex_q            <= 1'b0;
      rpt_valid_q     <= 1'b0;
      rpt_taken_q     <= 1'b0;
      pend_upd        <= nxt_pend_upd;
      pend_upd_class  <= nxt_pend_upd_class;
      pend_upd_repeat <= nxt_pend_upd_repeat;
      pend_ex         <= nxt_pend_ex;
      if (state == SETTLE) begin
        // F has now captured the block instruction's flag update.
        state       <= DECIDE;
        ready_q     <= 1'b0;
        rpt_valid_q <= 1'b1;
        if (cur_class == CLS_BLOCK_LD)
          rpt_taken_q <= (bus.F & 8'h04) != 8'h00;
        else if (cur_class == CLS_BLOCK_CP)
          rpt_taken_q <= (bus.F & 8'h44) == 8'h04;
      end else if (pick != SRC_NONE) begin
        state      <= ISSUE;
        ready_q    <= 1'b0;
        cur_repeat <= 1'b0;
        case (pick)
          SRC_POPF: write_f_q <= 1'b1;
          SRC_EX:   ex_q      <= 1'b1;
          SRC_UPD: begin
            strobe_q   <= pick_mask;
            select_q   <= pick_reserved ? '0 : pick_sel;
            cur_class  <= pick_class;
            cur_repeat <= pick_repeat & ~pick_reserved;
          end
          default: ;
        endcase
      end else if (state == ISSUE && cur_repeat) begin
        state   <= SETTLE;
        ready_q <= 1'b0;
      end else begin
        state      <= IDLE;
        ready_q    <= 1'b1;
        cur_repeat <= 1'b0;
      end
    end
  end

  assign bus.ready       = ready_q;
  assign bus.PF_Write_S  = strobe_q[5];
  assign bus.PF_Write_Z  = strobe_q[4];
  assign bus.PF_Write_H  = strobe_q[3];
  assign bus.PF_Write_PV = strobe_q[2];
  assign bus.PF_Write_N  = strobe_q[1];
  assign bus.PF_Write_C  = strobe_q[0];
  assign bus.PF_Select   = select_q;
  assign bus.PR_Write_F  = write_f_q;
  assign bus.PR_Ex       = ex_q;
  assign bus.rpt_valid   = rpt_valid_q;
  assign bus.rpt_taken   = rpt_taken_q;
endmodule
